noc_vc_input_buffer: RTL and testbench
======================================

NOC_VC_INPUT_BUFFER -- requirements
Module: noc_vc_input_buffer

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, flit width in bits.
REQ-002 SHALL provide parameter DEPTH, default 8, entries per virtual channel; power of 2, >= 2.
REQ-003 SHALL provide parameter NUM_VC, default 2, number of independent virtual channels, >= 2.
REQ-004 SHALL define VC_W = clog2(NUM_VC) and CNT_W = clog2(DEPTH)+1 as derived localparams.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-007 SHALL have port buf_data_i  input  DATA_W  write flit.
REQ-008 SHALL have port buf_write_i  input  1  write request.
REQ-009 SHALL have port buf_wvc_i  input  VC_W  target VC of write.
REQ-010 SHALL have port buf_read_i  input  1  read request.
REQ-011 SHALL have port buf_rvc_i  input  VC_W  source VC of read.
REQ-012 SHALL have port buf_data_o  output  DATA_W  registered read flit.
REQ-013 SHALL have port buf_valid_o  output  1  buf_data_o valid this cycle.
REQ-014 SHALL have port buf_vc_o  output  VC_W  VC of buf_data_o.
REQ-015 SHALL have port buf_empty_o  output  NUM_VC  per-VC empty, bit i = VC i.
REQ-016 SHALL have port buf_full_o  output  NUM_VC  per-VC full.
REQ-017 SHALL have port buf_count_o  output  NUM_VC*CNT_W  per-VC occupancy, VC i in bits [i*CNT_W +: CNT_W].
REQ-018 SHALL have port buf_overflow_o  output  1  sticky: write to full VC attempted.
REQ-019 SHALL have port buf_underflow_o  output  1  sticky: read from empty VC attempted.

Function
REQ-020 SHALL keep one circular FIFO per VC with CNT_W-bit read/write pointers (MSB = wrap bit); empty = pointers equal, full = low bits equal and wrap bits differ.
REQ-021 SHALL accept a write when buf_write_i=1 and buf_full_o[buf_wvc_i]=0, storing buf_data_i and advancing that VC's write pointer.
REQ-022 SHALL reject a write to a full VC, even with a simultaneous read of the same VC, leaving storage and pointers unchanged and setting buf_overflow_o.
REQ-023 SHALL accept a read when buf_read_i=1 and buf_empty_o[buf_rvc_i]=0, advancing that VC's read pointer.
REQ-024 SHALL reject a read of an empty VC, even with a simultaneous write to it, setting buf_underflow_o; buf_valid_o stays 0.
REQ-025 SHALL present an accepted read's flit on buf_data_o with buf_valid_o=1 and buf_vc_o=buf_rvc_i exactly one cycle after the request, valid for one cycle only.
REQ-026 SHALL hold buf_data_o and buf_vc_o at their last values while buf_valid_o=0.
REQ-027 SHALL have no fall-through: a flit written in cycle N is readable from cycle N+1 (empty/count update at the edge ending N).
REQ-028 SHALL, for simultaneous accepted read and write on the same VC, perform both and leave its count unchanged.
REQ-029 SHALL, for simultaneous accepted read and write on different VCs, update both VCs independently.
REQ-030 SHALL wrap pointers modulo 2*DEPTH with FIFO order preserved across wrap.
REQ-031 SHALL derive buf_empty_o, buf_full_o and buf_count_o from registered pointers only (no combinational path from inputs).
REQ-032 SHALL treat buf_wvc_i/buf_rvc_i >= NUM_VC as rejected requests setting the matching sticky flag.

Reset
REQ-033 SHALL, while reset=0, force all pointers to 0, buf_empty_o all 1, buf_full_o all 0, buf_count_o 0, buf_valid_o 0, buf_data_o 0, buf_vc_o 0, both sticky flags 0.
REQ-034 SHALL clear sticky flags only through reset.
REQ-035 SHALL not reset flit storage; contents are don't-care after reset.
REQ-036 SHALL discard any in-flight read on reset assertion: buf_valid_o=0 immediately (asynchronous).

Verification (DATA_W=16, DEPTH=8, NUM_VC=2)
REQ-037 SHALL cover: write 0x8000 VC0, read VC0 next cycle -> one cycle later buf_data_o=0x8000, buf_valid_o=1, buf_vc_o=0, buf_empty_o[0]=1.
REQ-038 SHALL cover: 8 writes VC1 (0x0001..0x0008) -> buf_full_o[1]=1, count VC1=8; 9th write 0xFFFF -> rejected, buf_overflow_o=1, VC0 still empty; 8 reads return 0x0001..0x0008 in order.
REQ-039 SHALL cover wrap: VC0 write 8, read 4, write 4 (0x0009..0x000C), read 8 -> 0x0005..0x000C in order, empty at end.
REQ-040 SHALL cover: VC0 count 3, write+read VC0 same cycle -> count stays 3; write VC0 + read VC1 (count 2) same cycle -> counts 4 and 1.
REQ-041 SHALL cover: read empty VC1 -> buf_valid_o=0, buf_underflow_o=1; write+read empty VC0 same cycle -> read rejected, count VC0=1.
REQ-042 SHALL cover: reset=0 asserted mid-stream with VC0 count 5 and read in flight -> all outputs at REQ-033 values immediately, held until reset=1.

Source files
------------

// File: rtl/noc_vc_input_buffer.sv
// Input buffer with one circular FIFO per virtual channel sharing a single storage array.
// One registered read per cycle. Sticky overflow/underflow flags clear only through reset.
module noc_vc_input_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int NUM_VC = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         buf_data_i,
    input  logic                      buf_write_i,
    input  logic [$clog2(NUM_VC)-1:0] buf_wvc_i,
    input  logic                      buf_read_i,
    input  logic [$clog2(NUM_VC)-1:0] buf_rvc_i,
    output logic [DATA_W-1:0]         buf_data_o,
    output logic                      buf_valid_o,
    output logic [$clog2(NUM_VC)-1:0] buf_vc_o,
    output logic [NUM_VC-1:0]         buf_empty_o,
    output logic [NUM_VC-1:0]         buf_full_o,
    output logic [NUM_VC*($clog2(DEPTH)+1)-1:0] buf_count_o,
    output logic                      buf_overflow_o,
    output logic                      buf_underflow_o
);
    localparam int VC_W  = $clog2(NUM_VC);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AW    = CNT_W - 1;

    // Storage is addressed as {vc, slot}; sized to the full VC index space so every address is legal.
    logic [DATA_W-1:0] mem [(2**VC_W)*DEPTH];

    logic [NUM_VC-1:0] w_acc;
    logic [NUM_VC-1:0] r_acc;
    logic [AW-1:0]     wr_addr [NUM_VC];
    logic [AW-1:0]     rd_addr [NUM_VC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
            logic [CNT_W-1:0] wr_ptr_reg;
            logic [CNT_W-1:0] rd_ptr_reg;
            logic             w_hit;
            logic             r_hit;

            assign w_hit = buf_write_i && (buf_wvc_i == VC_W'(gi));
            assign r_hit = buf_read_i  && (buf_rvc_i == VC_W'(gi));

            // Status comes from registered pointers only; acceptance uses the pre-edge state.
            assign buf_empty_o[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign buf_full_o[gi]  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
            assign buf_count_o[gi*CNT_W +: CNT_W] = wr_ptr_reg - rd_ptr_reg;

            assign w_acc[gi]   = w_hit && !buf_full_o[gi];
            assign r_acc[gi]   = r_hit && !buf_empty_o[gi];
            assign wr_addr[gi] = wr_ptr_reg[AW-1:0];
            assign rd_addr[gi] = rd_ptr_reg[AW-1:0];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (w_acc[gi]) wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
                    if (r_acc[gi]) rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (|w_acc) mem[{buf_wvc_i, wr_addr[buf_wvc_i]}] <= buf_data_i;
    end

    // A request to a full/empty or nonexistent VC never sets its accept bit, so it lands here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_data_o      <= '0;
            buf_valid_o     <= 1'b0;
            buf_vc_o        <= '0;
            buf_overflow_o  <= 1'b0;
            buf_underflow_o <= 1'b0;
        end else begin
            buf_valid_o <= |r_acc;
            if (|r_acc) begin
                buf_data_o <= mem[{buf_rvc_i, rd_addr[buf_rvc_i]}];
                buf_vc_o   <= buf_rvc_i;
            end
            if (buf_write_i && !(|w_acc)) buf_overflow_o  <= 1'b1;
            if (buf_read_i  && !(|r_acc)) buf_underflow_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed bench: stimulus pushes expected read flits into a scoreboard queue,
// a negedge monitor pops and compares whenever buf_valid_o is seen.
module tb_noc_vc_input_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] buf_data_i;
    logic        buf_write_i;
    logic [0:0]  buf_wvc_i;
    logic        buf_read_i;
    logic [0:0]  buf_rvc_i;
    logic [15:0] buf_data_o;
    logic        buf_valid_o;
    logic [0:0]  buf_vc_o;
    logic [1:0]  buf_empty_o;
    logic [1:0]  buf_full_o;
    logic [7:0]  buf_count_o;
    logic        buf_overflow_o;
    logic        buf_underflow_o;

    noc_vc_input_buffer #(.DATA_W(16), .DEPTH(8), .NUM_VC(2)) dut (
        .clk(clk), .reset(reset),
        .buf_data_i(buf_data_i), .buf_write_i(buf_write_i), .buf_wvc_i(buf_wvc_i),
        .buf_read_i(buf_read_i), .buf_rvc_i(buf_rvc_i),
        .buf_data_o(buf_data_o), .buf_valid_o(buf_valid_o), .buf_vc_o(buf_vc_o),
        .buf_empty_o(buf_empty_o), .buf_full_o(buf_full_o), .buf_count_o(buf_count_o),
        .buf_overflow_o(buf_overflow_o), .buf_underflow_o(buf_underflow_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vc;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, 32'(buf_empty_o), 32'h3);
        chk({tag, "_full"},  32'(buf_full_o),  32'h0);
        chk({tag, "_count"}, 32'(buf_count_o), 32'h0);
        chk({tag, "_valid"}, 32'(buf_valid_o), 32'h0);
        chk({tag, "_data"},  32'(buf_data_o),  32'h0);
        chk({tag, "_vc"},    32'(buf_vc_o),    32'h0);
        chk({tag, "_ovf"},   32'(buf_overflow_o),  32'h0);
        chk({tag, "_udf"},   32'(buf_underflow_o), 32'h0);
    endtask

    // One clock of stimulus; called 1 time unit after a rising edge.
    task automatic cyc(input logic w, input logic wvc, input logic [15:0] wd,
                       input logic r, input logic rvc,
                       input logic exp_rd, input logic [15:0] exp_d);
        buf_write_i = w;
        buf_wvc_i   = wvc;
        buf_data_i  = wd;
        buf_read_i  = r;
        buf_rvc_i   = rvc;
        if (exp_rd) sb.push_back({rvc, exp_d});
        @(posedge clk);
        #1;
        buf_write_i = 1'b0;
        buf_read_i  = 1'b0;
    endtask

    task automatic wr(input logic vc, input logic [15:0] d);
        cyc(1'b1, vc, d, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic rd(input logic vc, input logic [15:0] exp_d);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, vc, 1'b1, exp_d);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && buf_valid_o === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: got vc=%0d data=0x%04h, required no valid", buf_vc_o, buf_data_o);
            end else begin
                mon_e = sb.pop_front();
                if ({buf_vc_o, buf_data_o} !== mon_e) begin
                    fails++;
                    $display("FAIL rd_flit: got vc=%0d data=0x%04h, required vc=%0d data=0x%04h",
                             buf_vc_o, buf_data_o, mon_e.vc, mon_e.data);
                end else begin
                    $display("[TB] read vc=%0d data=0x%04h", buf_vc_o, buf_data_o);
                end
            end
        end
    end

    initial begin
        reset       = 1'b0;
        buf_data_i  = '0;
        buf_write_i = 1'b0;
        buf_wvc_i   = '0;
        buf_read_i  = 1'b0;
        buf_rvc_i   = '0;
        #12;
        chk_reset_state("rst0");
        @(posedge clk);
        #1 reset = 1'b1;

        // Single flit through VC0
        wr(1'b0, 16'h8000);
        chk("w1_empty", 32'(buf_empty_o), 32'h2);
        chk("w1_count0", 32'(buf_count_o[3:0]), 32'd1);
        rd(1'b0, 16'h8000);
        chk("r1_empty", 32'(buf_empty_o), 32'h3);
        chk("r1_valid", 32'(buf_valid_o), 32'h1);

        // Fill VC1, overflow, drain in order
        for (int i = 1; i <= 8; i++) wr(1'b1, 16'(i));
        chk("fill_full", 32'(buf_full_o), 32'h2);
        chk("fill_count1", 32'(buf_count_o[7:4]), 32'd8);
        wr(1'b1, 16'hFFFF);
        chk("ovf_flag", 32'(buf_overflow_o), 32'h1);
        chk("ovf_count1", 32'(buf_count_o[7:4]), 32'd8);
        chk("ovf_vc0_empty", 32'(buf_empty_o[0]), 32'h1);
        for (int i = 1; i <= 8; i++) rd(1'b1, 16'(i));
        chk("drain_empty", 32'(buf_empty_o), 32'h3);

        // Pointer wrap on VC0 (pointers start at 1 here)
        for (int i = 1; i <= 8; i++) wr(1'b0, 16'(i));
        chk("wrap_full0", 32'(buf_full_o), 32'h1);
        for (int i = 1; i <= 4; i++) rd(1'b0, 16'(i));
        for (int i = 9; i <= 12; i++) wr(1'b0, 16'(i));
        chk("wrap_refull", 32'(buf_full_o[0]), 32'h1);
        for (int i = 5; i <= 12; i++) rd(1'b0, 16'(i));
        chk("wrap_empty", 32'(buf_empty_o), 32'h3);

        // Simultaneous read/write, same and different VCs
        wr(1'b0, 16'h00A1);
        wr(1'b0, 16'h00A2);
        wr(1'b0, 16'h00A3);
        chk("sim_count0_pre", 32'(buf_count_o[3:0]), 32'd3);
        cyc(1'b1, 1'b0, 16'h00A4, 1'b1, 1'b0, 1'b1, 16'h00A1);
        chk("sim_same_count0", 32'(buf_count_o[3:0]), 32'd3);
        wr(1'b1, 16'h00B1);
        wr(1'b1, 16'h00B2);
        cyc(1'b1, 1'b0, 16'h00A5, 1'b1, 1'b1, 1'b1, 16'h00B1);
        chk("sim_diff_count0", 32'(buf_count_o[3:0]), 32'd4);
        chk("sim_diff_count1", 32'(buf_count_o[7:4]), 32'd1);
        rd(1'b0, 16'h00A2);
        rd(1'b1, 16'h00B2);
        rd(1'b0, 16'h00A3);
        rd(1'b0, 16'h00A4);
        rd(1'b0, 16'h00A5);
        chk("sim_drained", 32'(buf_empty_o), 32'h3);

        // Underflow: plain read of empty VC1, then write+read of empty VC0
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("udf_valid", 32'(buf_valid_o), 32'h0);
        chk("udf_flag", 32'(buf_underflow_o), 32'h1);
        chk("udf_ovf_sticky", 32'(buf_overflow_o), 32'h1);
        cyc(1'b1, 1'b0, 16'h00C1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("udf_wr_valid", 32'(buf_valid_o), 32'h0);
        chk("udf_wr_count0", 32'(buf_count_o[3:0]), 32'd1);
        rd(1'b0, 16'h00C1);

        // Asynchronous reset with a read in flight
        for (int i = 0; i < 5; i++) wr(1'b0, 16'h0050 + 16'(i));
        chk("mid_count0", 32'(buf_count_o[3:0]), 32'd5);
        buf_read_i = 1'b1;
        buf_rvc_i  = 1'b0;
        @(posedge clk);
        #1 buf_read_i = 1'b0;
        chk("mid_inflight_valid", 32'(buf_valid_o), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("mid_hold");
        reset = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
